stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Run-control FSM for the stopwatch. Sits between reset_debouncer-cleaned buttons and the
//   BCD counter / Display_Digits path in au_top. Turns button presses into count-enable,
//   clear and display-hold controls. Stops the count at full scale instead of wrapping.
// PARAMETERS
//   LONG_CYCLES  50_000_000  clk cycles lap_reset must be held to force a clear (LONGPRESS only)
//   LP_W         26          width of long-press counter; must satisfy 2**LP_W > LONG_CYCLES
// PORTS
//   clk          in   1  system clock; every register is clocked on its rising edge
//   rst_n        in   1  asynchronous active-low reset
//   start_stop   in   1  debounced level, start/stop button
//   lap_reset    in   1  debounced level, lap/reset button
//   tick         in   1  1-cycle count-rate pulse from Clock divider
//   at_max       in   1  counter currently holds its maximum value
//   cnt_en       out  1  increment strobe to counter
//   cnt_clr      out  1  1-cycle synchronous clear to counter
//   disp_hold    out  1  display latches and freezes the lap value while high
//   running      out  1  high in RUN or LAP
//   state        out  2  current FSM state, drives status leds
// BEHAVIOUR
//   Edges: ss_rise/lr_rise = level & ~prev. prev regs reset to 1, so a button already
//     held when rst_n releases produces no edge.
//   States: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11. Reset: IDLE.
//   IDLE : ss_rise->RUN; lr_rise->IDLE and pulse cnt_clr.
//   RUN  : ss_rise->PAUSE; lr_rise->LAP.
//   LAP  : ss_rise->PAUSE; lr_rise->RUN. Counter keeps counting in LAP.
//   PAUSE: ss_rise->RUN; lr_rise->IDLE and pulse cnt_clr.
//   Simultaneous ss_rise and lr_rise: ss_rise wins; lr_rise is dropped.
//   cnt_en = tick & running & ~at_max. Combinational from registered state, 0-cycle latency.
//     A tick in the same cycle as a transition uses the pre-transition state.
//   Saturation: tick & at_max in RUN/LAP -> PAUSE next cycle. No increment, no wrap.
//     Has priority over button edges in that cycle.
//   disp_hold = 1 only in LAP (registered state decode).
//   cnt_clr: registered; high exactly one cycle following the clearing edge.
//   Output reset values: cnt_en=0, cnt_clr=0, disp_hold=0, running=0, state=2'b00.
//   Mid-operation reset: everything returns to IDLE at once. No cnt_clr is issued; the
//     counter has its own rst_n.
// CONFIGURATION
//   `STOPWATCH_CTRL_LONGPRESS_EN defined:
//     - Saturating LP_W counter counts cycles with lap_reset high; it clears when lap_reset is low.
//     - The cycle it reaches LONG_CYCLES: force IDLE and pulse cnt_clr from any state.
//       This beats every other transition in that cycle.
//     - Fires once per press, since the counter saturates and does not refire.
//     - The lr_rise action taken at the start of that press still occurs.
//   Not defined: no counter logic; LONG_CYCLES and LP_W are unused; ports unchanged.
// STRUCTURE
//   stopwatch_ctrl_pkg.vh: state encodings (ST_IDLE, ST_RUN, ST_PAUSE, ST_LAP), state width.
//     Shared with the au_top led decode.
//   Sub-module btn_edge: one prev register plus rise output, reset value 1.
//     Instantiated twice (start_stop, lap_reset).
// TESTING (bench: LONG_CYCLES=16, tick every 10 clk)
//   1. Hold start_stop=1 through reset release -> state stays 00, cnt_en=0.
//   2. ss press; run 5 ticks -> state=01, 5 cnt_en pulses; ss press -> 10, no further cnt_en.
//   3. From RUN: lr press -> state=11, disp_hold=1, cnt_en still follows tick.
//      lr press -> 01, disp_hold=0.
//   4. In PAUSE: lr press -> cnt_clr high exactly 1 cycle, state=00.
//      Same-cycle ss+lr rise from RUN -> state=10, no LAP.
//   5. RUN with at_max=1 at tick -> cnt_en stays 0, state=10 next cycle.
//   6. LONGPRESS_EN: hold lr 16 cycles in RUN -> one cnt_clr, state=00.
//      Holding 40 cycles -> still one pulse. Macro off: state 11, no cnt_clr.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch run-control block: state encodings and decode helpers.
// Also consumed by the top-level status-led decode.
package stopwatch_ctrl_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_e;

    function automatic logic is_running(input state_e s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage : stopwatch_ctrl_pkg

// File: rtl/stopwatch_ctrl_if.sv
// Control bundle between the cleaned buttons / counter and the stopwatch run-control FSM.
interface stopwatch_ctrl_if;
    import stopwatch_ctrl_pkg::*;

    logic            start_stop;
    logic            lap_reset;
    logic            tick;
    logic            at_max;
    logic            cnt_en;
    logic            cnt_clr;
    logic            disp_hold;
    logic            running;
    logic [ST_W-1:0] state;

    modport master (
        output start_stop, lap_reset, tick, at_max,
        input  cnt_en, cnt_clr, disp_hold, running, state
    );

    modport slave (
        input  start_stop, lap_reset, tick, at_max,
        output cnt_en, cnt_clr, disp_hold, running, state
    );

endinterface : stopwatch_ctrl_if

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Rising-edge detector for a debounced button level. The history register resets high so a
// button already held at reset release does not produce a spurious press.
module stopwatch_ctrl_btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;

    // Previous-level history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_i;
        end
    end

    // Rise decode
    always_comb begin
        rise_o = level_i & ~prev_q;
    end

endmodule : stopwatch_ctrl_btn_edge

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control FSM: buttons -> count enable, counter clear and display hold.
// Optional long-press clear on lap_reset is enabled with `STOPWATCH_CTRL_LONGPRESS_EN.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int LONG_CYCLES = 50_000_000,
    parameter int LP_W        = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    stopwatch_ctrl_if.slave  sw
);

    state_e state_q;
    state_e state_d;
    logic   cnt_clr_q;
    logic   cnt_clr_d;
    logic   ss_rise_s;
    logic   lr_rise_s;
    logic   sat_s;
    logic   lp_fire_s;

    stopwatch_ctrl_btn_edge u_ss_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (sw.start_stop),
        .rise_o  (ss_rise_s)
    );

    stopwatch_ctrl_btn_edge u_lr_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (sw.lap_reset),
        .rise_o  (lr_rise_s)
    );

`ifdef STOPWATCH_CTRL_LONGPRESS_EN
    localparam logic [LP_W-1:0] LP_FULL = LP_W'(LONG_CYCLES);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_CYCLES - 1);

    logic [LP_W-1:0] lp_cnt_q;
    logic [LP_W-1:0] lp_cnt_d;

    // Hold-time counter: saturates at LONG_CYCLES so each press fires only once
    always_comb begin
        lp_cnt_d = lp_cnt_q;
        if (!sw.lap_reset) begin
            lp_cnt_d = {LP_W{1'b0}};
        end else if (lp_cnt_q != LP_FULL) begin
            lp_cnt_d = lp_cnt_q + {{(LP_W-1){1'b0}}, 1'b1};
        end else begin
            lp_cnt_d = lp_cnt_q;
        end
    end

    // Hold-time counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_cnt_q <= {LP_W{1'b0}};
        end else begin
            lp_cnt_q <= lp_cnt_d;
        end
    end

    // Fires in the cycle the count reaches LONG_CYCLES
    always_comb begin
        lp_fire_s = sw.lap_reset & (lp_cnt_q == LP_LAST);
    end
`else
    // Long-press clear not built
    always_comb begin
        lp_fire_s = 1'b0;
    end
`endif

    // Count would pass full scale: stop instead of wrapping
    always_comb begin
        sat_s = sw.tick & sw.at_max & is_running(state_q);
    end

    // State and clear-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_clr_q <= cnt_clr_d;
        end
    end

    // Next-state logic; priority: long-press, saturation, start/stop, lap/reset
    always_comb begin
        state_d   = state_q;
        cnt_clr_d = 1'b0;
        if (lp_fire_s) begin
            state_d   = ST_IDLE;
            cnt_clr_d = 1'b1;
        end else if (sat_s) begin
            state_d = ST_PAUSE;
        end else if (ss_rise_s) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_LAP:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end else if (lr_rise_s) begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_IDLE;
                    cnt_clr_d = 1'b1;
                end
                ST_RUN:   state_d = ST_LAP;
                ST_LAP:   state_d = ST_RUN;
                ST_PAUSE: begin
                    state_d   = ST_IDLE;
                    cnt_clr_d = 1'b1;
                end
                default:  state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output decode; cnt_en is zero-latency from the registered state
    always_comb begin
        sw.state     = state_q;
        sw.running   = is_running(state_q);
        sw.disp_hold = (state_q == ST_LAP);
        sw.cnt_clr   = cnt_clr_q;
        sw.cnt_en    = sw.tick & is_running(state_q) & ~sw.at_max;
    end

endmodule : stopwatch_ctrl

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (LONG_CYCLES=16, tick every 10 clk).
module tb_stopwatch_ctrl;

    typedef struct packed {
        logic [1:0] st;
        logic       en;
        logic       clr;
        logic       hold;
        logic       run;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   cyc;
    int   en_seen;
    int   clr_seen;
    exp_t exp_q[$];

    logic [1:0] m_state;
    logic       m_clr;
    logic       m_prev_ss;
    logic       m_prev_lr;
    int         m_lp;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(
        .LONG_CYCLES (16),
        .LP_W        (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = 2'b00;
        m_clr     = 1'b0;
        m_prev_ss = 1'b1;
        m_prev_lr = 1'b1;
        m_lp      = 0;
    endtask

    // One clock of stimulus: expected outputs are pushed, then popped at the negedge
    task automatic drive(input logic ss, input logic lr, input logic tk, input logic mx);
        exp_t       e;
        exp_t       got;
        logic       ss_r;
        logic       lr_r;
        logic       run;
        logic [1:0] nst;
        logic       nclr;
        @(posedge clk);
        #1;
        sw_if.start_stop = ss;
        sw_if.lap_reset  = lr;
        sw_if.tick       = tk;
        sw_if.at_max     = mx;
        cyc++;
        ss_r   = ss & ~m_prev_ss;
        lr_r   = lr & ~m_prev_lr;
        run    = (m_state == 2'b01) || (m_state == 2'b11);
        e.st   = m_state;
        e.en   = tk & run & ~mx;
        e.clr  = m_clr;
        e.hold = (m_state == 2'b11);
        e.run  = run;
        exp_q.push_back(e);
        nst  = m_state;
        nclr = 1'b0;
        if (tk && mx && run) begin
            nst = 2'b10;
        end else if (ss_r) begin
            nst = ((m_state == 2'b00) || (m_state == 2'b10)) ? 2'b01 : 2'b10;
        end else if (lr_r) begin
            case (m_state)
                2'b00: nclr = 1'b1;
                2'b01: nst = 2'b11;
                2'b11: nst = 2'b01;
                default: begin nst = 2'b00; nclr = 1'b1; end
            endcase
        end
`ifdef STOPWATCH_CTRL_LONGPRESS_EN
        if (lr) begin
            if (m_lp < 16) begin
                m_lp++;
                if (m_lp == 16) begin
                    nst  = 2'b00;
                    nclr = 1'b1;
                end
            end
        end else begin
            m_lp = 0;
        end
`endif
        m_state   = nst;
        m_clr     = nclr;
        m_prev_ss = ss;
        m_prev_lr = lr;
        @(negedge clk);
        got.st   = sw_if.state;
        got.en   = sw_if.cnt_en;
        got.clr  = sw_if.cnt_clr;
        got.hold = sw_if.disp_hold;
        got.run  = sw_if.running;
        if (got.en === 1'b1) en_seen++;
        if (got.clr === 1'b1) clr_seen++;
        e = exp_q.pop_front();
        check_eq("sb_state", 32'(got.st), 32'(e.st));
        check_eq("sb_cnt_en", 32'(got.en), 32'(e.en));
        check_eq("sb_cnt_clr", 32'(got.clr), 32'(e.clr));
        check_eq("sb_disp_hold", 32'(got.hold), 32'(e.hold));
        check_eq("sb_running", 32'(got.run), 32'(e.run));
    endtask

    task automatic run_cycles(input int n, input logic lr, input logic tick_on, input logic mx);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, lr, tick_on && ((cyc % 10) == 9), mx);
        end
    endtask

    task automatic press_ss();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_lr();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        en_seen  = 0;
        clr_seen = 0;
        rst_n            = 1'b0;
        sw_if.start_stop = 1'b1;
        sw_if.lap_reset  = 1'b0;
        sw_if.tick       = 1'b0;
        sw_if.at_max     = 1'b0;
        model_reset();

        // Reset values, start_stop held through release
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", 32'(sw_if.state), 0);
        check_eq("rst_cnt_en", 32'(sw_if.cnt_en), 0);
        check_eq("rst_cnt_clr", 32'(sw_if.cnt_clr), 0);
        check_eq("rst_disp_hold", 32'(sw_if.disp_hold), 0);
        check_eq("rst_running", 32'(sw_if.running), 0);
        rst_n     = 1'b1;
        m_prev_ss = sw_if.start_stop;
        m_prev_lr = sw_if.lap_reset;
        repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("held_ss_idle", 32'(sw_if.state), 0);

        // Run five ticks, then pause
        press_ss();
        en_seen = 0;
        run_cycles(50, 1'b0, 1'b1, 1'b0);
        check_eq("run_5_ticks", en_seen, 5);
        check_eq("run_state", 32'(sw_if.state), 1);
        press_ss();
        en_seen = 0;
        run_cycles(20, 1'b0, 1'b1, 1'b0);
        check_eq("pause_no_en", en_seen, 0);
        check_eq("pause_state", 32'(sw_if.state), 2);

        // Lap: counting continues, display held
        press_ss();
        press_lr();
        check_eq("lap_state", 32'(sw_if.state), 3);
        check_eq("lap_hold", 32'(sw_if.disp_hold), 1);
        en_seen = 0;
        run_cycles(20, 1'b0, 1'b1, 1'b0);
        check_eq("lap_ticks", en_seen, 2);
        press_lr();
        check_eq("unlap_state", 32'(sw_if.state), 1);
        check_eq("unlap_hold", 32'(sw_if.disp_hold), 0);

        // Clear from PAUSE, then simultaneous presses from RUN
        press_ss();
        clr_seen = 0;
        press_lr();
        run_cycles(3, 1'b0, 1'b0, 1'b0);
        check_eq("clr_once", clr_seen, 1);
        check_eq("clr_state", 32'(sw_if.state), 0);
        press_ss();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("ss_wins_state", 32'(sw_if.state), 2);

        // Saturation, alone and against a lap press
        press_ss();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("sat_state", 32'(sw_if.state), 2);
        press_ss();
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("sat_beats_lr", 32'(sw_if.state), 2);

        // Reset while running
        press_ss();
        run_cycles(5, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n            = 1'b0;
        sw_if.start_stop = 1'b0;
        sw_if.lap_reset  = 1'b0;
        sw_if.tick       = 1'b0;
        sw_if.at_max     = 1'b0;
        #1;
        check_eq("midrst_state", 32'(sw_if.state), 0);
        check_eq("midrst_clr", 32'(sw_if.cnt_clr), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m_prev_ss = sw_if.start_stop;
        m_prev_lr = sw_if.lap_reset;

        // Long press of lap_reset while running
        press_ss();
        clr_seen = 0;
        run_cycles(16, 1'b1, 1'b0, 1'b0);
        run_cycles(3, 1'b0, 1'b0, 1'b0);
`ifdef STOPWATCH_CTRL_LONGPRESS_EN
        check_eq("lp16_clr", clr_seen, 1);
        check_eq("lp16_state", 32'(sw_if.state), 0);
        press_ss();
`else
        check_eq("lp16_clr", clr_seen, 0);
        check_eq("lp16_state", 32'(sw_if.state), 3);
        press_ss();
        press_ss();
`endif
        clr_seen = 0;
        run_cycles(40, 1'b1, 1'b0, 1'b0);
        run_cycles(3, 1'b0, 1'b0, 1'b0);
`ifdef STOPWATCH_CTRL_LONGPRESS_EN
        check_eq("lp40_clr", clr_seen, 1);
        check_eq("lp40_state", 32'(sw_if.state), 0);
`else
        check_eq("lp40_clr", clr_seen, 0);
        check_eq("lp40_state", 32'(sw_if.state), 3);
`endif
        check_eq("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_stopwatch_ctrl
